booth_radix4_multiplier: RTL and testbench

Sequential radix-4 (modified Booth) multiplier, parameterised on operand width N, with a per-operation signed/unsigned mode. It retires two multiplier bits per clock using a single combined add/shift step, roughly halving the latency of the radix-2 multiplier. It registers the product and holds it until the next operation. It sits in the datapath as a drop-in, start/done-handshaked multiplier for both signed and unsigned operands.

---
 rtl/booth_radix4_multiplier.sv | 165 ++++++++++++++++
 tb/tb_booth_radix4_multiplier.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier, signed/unsigned per operation.
// Define BOOTH_EARLY_TERM_EN to finish early once the remaining digits are zero.
module booth_radix4_multiplier #(
  parameter int N = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [N-1:0]     multiplicand,
  input  logic [N-1:0]     multiplier,
  output logic [2*N-1:0]   product,
  output logic             done,
  output logic             busy
);

  localparam int K  = N/2 + 1;
  localparam int CW = $clog2(K+1);
  localparam int RW = 2*N + 6;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [N+2:0]     acc_q, acc_d;
  logic [N+1:0]     y_q, y_d;
  logic             ref_q, ref_d;
  logic [N:0]       me_q, me_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   prod_q, prod_d;
  logic             done_q, done_d;

  logic [N:0]       me_ext;
  logic [N+1:0]     ye_ext;
  logic [N+2:0]     me_w;
  logic [N+2:0]     me2_w;
  logic [N+2:0]     addend;
  logic [N+2:0]     sum;
  logic [RW-1:0]    full;
  logic signed [RW-1:0] shres;
  logic             last;
  logic             fin;

`ifdef BOOTH_EARLY_TERM_EN
  localparam int SW = $clog2(2*K+1);
  logic [N:0]       ys_q, ys_d;
  logic             tail0;
  logic [SW-1:0]    sh_amt;
`endif

  always_comb begin
    me_ext = {is_signed & multiplicand[N-1], multiplicand};
    ye_ext = {{2{is_signed & multiplier[N-1]}}, multiplier};
    me_w   = {{2{me_q[N]}}, me_q};
    me2_w  = me_w << 1;

    unique case ({y_q[1:0], ref_q})
      3'b000, 3'b111: addend = '0;
      3'b001, 3'b010: addend = me_w;
      3'b011:         addend = me2_w;
      3'b100:         addend = -me2_w;
      3'b101, 3'b110: addend = -me_w;
      default:        addend = '0;
    endcase

    sum  = acc_q + addend;
    full = {sum, y_q, ref_q};
    last = (cnt_q == CW'(K-1));

`ifdef BOOTH_EARLY_TERM_EN
    // ys_q holds the multiplier bits feeding all later digits
    tail0  = (&ys_q) | ~(|ys_q);
    fin    = last | tail0;
    sh_amt = fin ? SW'(2*(K - int'(cnt_q))) : SW'(2);
    shres  = $signed(full) >>> sh_amt;
`else
    fin    = last;
    shres  = $signed(full) >>> 2;
`endif
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    y_d     = y_q;
    ref_d   = ref_q;
    me_d    = me_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
`ifdef BOOTH_EARLY_TERM_EN
    ys_d    = ys_q;
`endif

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = CALC;
          acc_d   = '0;
          y_d     = ye_ext;
          ref_d   = 1'b0;
          me_d    = me_ext;
          prod_d  = '0;
`ifdef BOOTH_EARLY_TERM_EN
          ys_d    = ye_ext[N+1:1];
`endif
        end
      end
      CALC: begin
        {acc_d, y_d, ref_d} = shres;
        cnt_d = cnt_q + CW'(1);
`ifdef BOOTH_EARLY_TERM_EN
        ys_d  = (N+1)'($signed(ys_q) >>> 2);
`endif
        if (fin) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // {acc, y} now equals Me*Ye; keep the low 2N bits
        prod_d  = {acc_q[N-3:0], y_q};
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      y_q     <= '0;
      ref_q   <= 1'b0;
      me_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
`ifdef BOOTH_EARLY_TERM_EN
      ys_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      ref_q   <= ref_d;
      me_q    <= me_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
`ifdef BOOTH_EARLY_TERM_EN
      ys_q    <= ys_d;
`endif
    end
  end

  assign product = prod_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Bench for booth_radix4_multiplier (N=8): directed corners plus random ops
// against an integer-product reference model.
module tb_booth_radix4_multiplier;

  localparam int N = 8;

`ifdef BOOTH_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          is_signed;
  logic [N-1:0]  multiplicand;
  logic [N-1:0]  multiplier;
  logic [2*N-1:0] product;
  logic          done;
  logic          busy;

  int checks = 0;
  int errors = 0;

  booth_radix4_multiplier #(.N(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .done         (done),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] model(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input bit s);
    longint ma;
    longint mb;
    ma = s ? longint'($signed(a)) : longint'({56'b0, a});
    mb = s ? longint'($signed(b)) : longint'({56'b0, b});
    return 16'(ma * mb);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input bit s,
                        input int exp_lat,
                        input bit exact,
                        input bit inject);
    logic [15:0] exp_p;
    int lat;
    exp_p = model(a, b, s);
    @(negedge clock);
    start = 1'b1;
    multiplicand = a;
    multiplier = b;
    is_signed = s;
    @(negedge clock);
    start = 1'b0;
    multiplicand = 8'($urandom);
    multiplier = 8'($urandom);
    is_signed = 1'($urandom);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".clr"}, 32'(product), 32'd0);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clock);
      lat++;
      if (inject && lat == 1) start = 1'b1;
      if (inject && lat == 2) start = 1'b0;
      if (inject && lat == exp_lat - 1) start = 1'b1;
    end
    start = 1'b0;
    chk({tag, ".done"}, 32'(done), 32'd1);
    if (exact)
      chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    else
      chk({tag, ".latmax"}, 32'(lat <= exp_lat), 32'd1);
    chk({tag, ".prod"}, 32'(product), 32'(exp_p));
    @(negedge clock);
    chk({tag, ".pulse"}, 32'(done), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
    chk({tag, ".hold"}, 32'(product), 32'(exp_p));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (3) @(negedge clock);
    chk("rst.product", 32'(product), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    reset = 1'b0;

    run_op("sgn_corner", 8'h80, 8'h80, 1'b1, 6, !ET, 1'b0);
    chk("sgn_corner.val", 32'(product), 32'h4000);
    run_op("uns_max", 8'hFF, 8'hFF, 1'b0, 6, !ET, 1'b0);
    chk("uns_max.val", 32'(product), 32'hFE01);
    run_op("sgn_m1", 8'hFF, 8'hFF, 1'b1, 6, !ET, 1'b0);
    chk("sgn_m1.val", 32'(product), 32'h0001);
    run_op("mix1", 8'h07, 8'hFD, 1'b1, 6, !ET, 1'b0);
    chk("mix1.val", 32'(product), 32'hFFEB);
    run_op("mix2", 8'h80, 8'h7F, 1'b1, 6, !ET, 1'b0);
    repeat (4) @(negedge clock);
    chk("mix2.hold4", 32'(product), 32'hC080);

    run_op("hshake", 8'h9C, 8'hAA, 1'b0, 6, 1'b1, 1'b1);
    repeat (2) @(negedge clock);
    chk("hshake.nodone", 32'(done), 32'd0);
    chk("hshake.val", 32'(product), 32'(model(8'h9C, 8'hAA, 1'b0)));

    @(negedge clock);
    start = 1'b1;
    multiplicand = 8'h37;
    multiplier = 8'hAA;
    is_signed = 1'b0;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("mrst.busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("mrst.product", 32'(product), 32'd0);
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.done", 32'(done), 32'd0);
    reset = 1'b0;
    run_op("after_rst", 8'd12, 8'd12, 1'b0, 6, !ET, 1'b0);
    chk("after_rst.val", 32'(product), 32'h0090);

`ifdef BOOTH_EARLY_TERM_EN
    run_op("et_200x1", 8'd200, 8'd1, 1'b0, 2, 1'b1, 1'b0);
    chk("et_200x1.val", 32'(product), 32'h00C8);
    run_op("et_5xm1", 8'd5, 8'hFF, 1'b1, 2, 1'b1, 1'b0);
    chk("et_5xm1.val", 32'(product), 32'hFFFB);
    run_op("et_55", 8'h55, 8'h55, 1'b0, 6, 1'b0, 1'b0);
    chk("et_55.val", 32'(product), 32'h1C39);
`endif

    repeat (40) begin
      logic [7:0] ra;
      logic [7:0] rb;
      bit rs;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      run_op("rnd", ra, rb, rs, 6, !ET, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
